// File: rtl/wb_merge.sv
// wb_merge: writeback merge stage in front of the register file write port.
// The pipeline writeback has priority. Late results (loads, MMIO, multi-cycle
// units) queue in a small FIFO and drain in cycles the pipeline leaves the
// port free. A starvation counter asks upstream for a bubble when the FIFO
// has been blocked for too long.
// Optional feature macro: WB_MERGE_SCOREBOARD_EN builds the per-register busy
// scoreboard. Without it, busy is tied to 0 and the claim inputs are ignored.
module wb_merge #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pipe_we,
  input  logic [4:0]                    pipe_rd,
  input  logic [31:0]                   pipe_data,
  input  logic                          late_valid,
  output logic                          late_ready,
  input  logic [4:0]                    late_rd,
  input  logic [31:0]                   late_data,
  input  logic                          claim_valid,
  input  logic [4:0]                    claim_rd,
  output logic [31:0]                   busy,
  output logic                          stall_req,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          rf_write,
  output logic [4:0]                    rf_wrAddr,
  output logic [31:0]                   rf_wrData
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // Each entry is {rd, data}
  logic [36:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [7:0]     starve_q, starve_d;
  logic           stall_q, stall_d;
  logic           rf_write_q, rf_write_d;
  logic [4:0]     rf_addr_q, rf_addr_d;
  logic [31:0]    rf_data_q, rf_data_d;

  logic           pipe_hit;
  logic           fifo_empty;
  logic           fifo_full;
  logic           push;
  logic           pop;
  logic [36:0]    head;
  logic [4:0]     head_rd;

  // A pipeline write to x0 is no write, so it leaves the port free.
  // The head is only popped from entries already stored (no same-cycle bypass).
  always_comb begin
    pipe_hit   = pipe_we && (pipe_rd != 5'd0);
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CW'(FIFO_DEPTH));
    late_ready = !fifo_full && rst_n;
    push       = late_valid && late_ready;
    pop        = !pipe_hit && !fifo_empty;
    head       = mem_q[rd_ptr_q];
    head_rd    = head[36:32];
  end

  // Next-state for FIFO pointers, occupancy, write port and starvation tracking
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rf_write_d = 1'b0;
    rf_addr_d  = rf_addr_q;
    rf_data_d  = rf_data_q;
    starve_d   = starve_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    if (pipe_hit) begin
      rf_write_d = 1'b1;
      rf_addr_d  = pipe_rd;
      rf_data_d  = pipe_data;
    end else if (pop) begin
      rf_write_d = (head_rd != 5'd0);
      rf_addr_d  = head_rd;
      rf_data_d  = head[31:0];
    end

    if (pop || fifo_empty)
      starve_d = 8'd0;
    else if (starve_q != 8'(STARVE_LIMIT))
      starve_d = starve_q + 8'd1;

    stall_d = (starve_d == 8'(STARVE_LIMIT));
  end

  // Control and write-port state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= 8'd0;
      stall_q    <= 1'b0;
      rf_write_q <= 1'b0;
      rf_addr_q  <= 5'd0;
      rf_data_q  <= 32'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      stall_q    <= stall_d;
      rf_write_q <= rf_write_d;
      rf_addr_q  <= rf_addr_d;
      rf_data_q  <= rf_data_d;
    end
  end

  // FIFO storage; contents are only meaningful under the pointers, so no reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {late_rd, late_data};
  end

`ifdef WB_MERGE_SCOREBOARD_EN
  logic [31:0] busy_q, busy_d;

  // Clear on the draining write, set on claim; a same-cycle claim wins
  always_comb begin
    busy_d = busy_q;
    if (pop && (head_rd != 5'd0)) busy_d[head_rd] = 1'b0;
    if (claim_valid && (claim_rd != 5'd0)) busy_d[claim_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= 32'd0;
    else        busy_q <= busy_d;
  end

  assign busy = busy_q;
`else
  logic unused_claim;
  assign unused_claim = ^{claim_valid, claim_rd};
  assign busy         = 32'd0;
`endif

  assign fifo_count = count_q;
  assign stall_req  = stall_q;
  assign rf_write   = rf_write_q;
  assign rf_wrAddr  = rf_addr_q;
  assign rf_wrData  = rf_data_q;

endmodule

// File: tb/tb_wb_merge.sv
// tb_wb_merge: directed and randomized checks of wb_merge against a
// queue-based reference model. Works with or without WB_MERGE_SCOREBOARD_EN.
module tb_wb_merge;
  localparam int DEPTH = 2;
  localparam int LIMIT = 8;

  logic        clk;
  logic        rst_n;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        late_valid;
  logic        late_ready;
  logic [4:0]  late_rd;
  logic [31:0] late_data;
  logic        claim_valid;
  logic [4:0]  claim_rd;
  logic [31:0] busy;
  logic        stall_req;
  logic [1:0]  fifo_count;
  logic        rf_write;
  logic [4:0]  rf_wrAddr;
  logic [31:0] rf_wrData;

  wb_merge #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .late_valid(late_valid), .late_ready(late_ready),
    .late_rd(late_rd), .late_data(late_data),
    .claim_valid(claim_valid), .claim_rd(claim_rd),
    .busy(busy), .stall_req(stall_req), .fifo_count(fifo_count),
    .rf_write(rf_write), .rf_wrAddr(rf_wrAddr), .rf_wrData(rf_wrData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [36:0] q[$];
  int          starve;
  logic [31:0] m_busy;
  logic        m_wr;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    starve = 0;
    m_busy = 32'd0;
    m_wr   = 1'b0;
    m_addr = 5'd0;
    m_data = 32'd0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".rf_write"},   32'(rf_write),   32'(m_wr));
    chk({tag, ".rf_wrAddr"},  32'(rf_wrAddr),  32'(m_addr));
    chk({tag, ".rf_wrData"},  rf_wrData,       m_data);
    chk({tag, ".fifo_count"}, 32'(fifo_count), 32'(q.size()));
    chk({tag, ".stall_req"},  32'(stall_req),  32'(starve == LIMIT));
    chk({tag, ".busy"},       busy,            m_busy);
  endtask

  // One clock cycle: drive inputs, check ready, advance model, check outputs.
  // Called 1 time unit after a rising edge.
  task automatic step(input string tag,
                      input logic pw, input logic [4:0] prd, input logic [31:0] pd,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                      input logic cv, input logic [4:0] crd);
    logic        exp_ready, occ, was_empty, popped;
    logic [36:0] h;
    pipe_we = pw; pipe_rd = prd; pipe_data = pd;
    late_valid = lv; late_rd = lrd; late_data = ld;
    claim_valid = cv; claim_rd = crd;
    #1;
    exp_ready = (q.size() < DEPTH);
    chk({tag, ".late_ready"}, 32'(late_ready), 32'(exp_ready));
    @(posedge clk);
    occ       = pw && (prd != 5'd0);
    was_empty = (q.size() == 0);
    popped    = 1'b0;
    if (occ) begin
      m_wr = 1'b1; m_addr = prd; m_data = pd;
    end else if (!was_empty) begin
      h = q.pop_front();
      popped = 1'b1;
      m_addr = h[36:32];
      m_data = h[31:0];
      m_wr   = (m_addr != 5'd0);
`ifdef WB_MERGE_SCOREBOARD_EN
      if (m_addr != 5'd0) m_busy[m_addr] = 1'b0;
`endif
    end else begin
      m_wr = 1'b0;
    end
    if (lv && exp_ready) q.push_back({lrd, ld});
    if (popped || was_empty) starve = 0;
    else if (starve < LIMIT) starve++;
`ifdef WB_MERGE_SCOREBOARD_EN
    if (cv && crd != 5'd0) m_busy[crd] = 1'b1;
`endif
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    pipe_we = 1'b0; pipe_rd = 5'd0; pipe_data = 32'd0;
    late_valid = 1'b0; late_rd = 5'd0; late_data = 32'd0;
    claim_valid = 1'b0; claim_rd = 5'd0;
    model_reset();
    #2;
    check_outputs("reset");
    chk("reset.late_ready", 32'(late_ready), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Pipeline priority over a same-cycle late accept
    step("prio0", 1'b1, 5'd3, 32'hA5A5A5A5, 1'b1, 5'd7, 32'h11, 1'b0, 5'd0);
    chk("prio0.addr", 32'(rf_wrAddr), 32'd3);
    step("prio1", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("prio1.addr", 32'(rf_wrAddr), 32'd7);
    chk("prio1.data", rf_wrData, 32'h11);
    idle("prio2");

    // FIFO full under a blocking pipeline, then starvation and a bubble
    for (int i = 0; i < 3; i++)
      step("full_in", 1'b1, 5'd1, 32'(i), 1'b1, 5'(10 + i), 32'(100 + i), 1'b0, 5'd0);
    chk("full.count", 32'(fifo_count), 32'd2);
    chk("full.ready", 32'(late_ready), 32'd0);
    for (int i = 0; i < 8; i++)
      step("starve", 1'b1, 5'd1, 32'(i), 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("starve.stall", 32'(stall_req), 32'd1);
    idle("bubble");
    chk("bubble.addr", 32'(rf_wrAddr), 32'd10);
    chk("bubble.stall", 32'(stall_req), 32'd0);
    idle("drain");
    chk("drain.addr", 32'(rf_wrAddr), 32'd11);
    idle("drain_done");

    // x0 handling
    step("x0_push", 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0);
    step("x0_pop", 1'b1, 5'd0, 32'h5, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("x0_pop.we", 32'(rf_write), 32'd0);
    step("x0_q4", 1'b1, 5'd1, 32'h77, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0);
    step("x0_free", 1'b1, 5'd0, 32'h9, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("x0_free.addr", 32'(rf_wrAddr), 32'd4);
    chk("x0_free.we", 32'(rf_write), 32'd1);

    // Scoreboard: claim, drain with re-claim, drain without
    step("sb_claim", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    step("sb_push", 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0);
    step("sb_reclaim", 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h98, 1'b1, 5'd9);
    chk("sb_reclaim.addr", 32'(rf_wrAddr), 32'd9);
    step("sb_clear", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("sb_clear.data", rf_wrData, 32'h98);
    chk("sb_clear.busy9", 32'(busy[9]), 32'd0);

    // Reset mid-traffic
    step("rm_claim", 1'b1, 5'd1, 32'd0, 1'b1, 5'd5, 32'h55, 1'b1, 5'd5);
    step("rm_push", 1'b1, 5'd1, 32'd0, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0);
    pipe_we = 1'b0; late_valid = 1'b0; claim_valid = 1'b0;
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("rst_mid");
    chk("rst_mid.late_ready", 32'(late_ready), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    idle("post_rst0");
    idle("post_rst1");

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      step("rand", ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 31)), $urandom(),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
           ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)));
    for (int i = 0; i < 4; i++) idle("rand_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_merge.md
# wb_merge

Writeback merge stage sitting directly upstream of the register file write port. Merges the single-cycle pipeline writeback with out-of-order late results from loads, MMIO and multi-cycle units into one registered write port. Late results are buffered in a small FIFO that drains only in cycles the pipeline leaves the port free. An optional scoreboard tracks registers with outstanding late writes so decode can stall on RAW/WAW hazards.

## Interface
- `FIFO_DEPTH`, default 2: late-result FIFO entries; power of two, ≥2.
- `STARVE_LIMIT`, default 8: consecutive blocked-drain cycles before `stall_req` asserts; 1..255.

- `clk`: input, 1 bit. Single clock; all state changes on the rising edge.
- `rst_n`: input, 1 bit. Asynchronous, active-low reset.
- `pipe_we`: input, 1 bit. Pipeline writeback valid. No backpressure.
- `pipe_rd`: input, 5 bits. Pipeline destination register.
- `pipe_data`: input, 32 bits. Pipeline result.
- `late_valid`: input, 1 bit. Late result offered.
- `late_ready`: output, 1 bit. Late result can be accepted.
- `late_rd`: input, 5 bits. Late result destination register.
- `late_data`: input, 32 bits. Late result.
- `claim_valid`: input, 1 bit. Issue stage reserves `claim_rd` for a future late write.
- `claim_rd`: input, 5 bits. Register being reserved.
- `busy`: output, 32 bits. Per-register outstanding-late-write mask; bit 0 is always 0.
- `stall_req`: output, 1 bit. Asks upstream to bubble `pipe_we` so the FIFO can drain.
- `fifo_count`: output, $clog2(FIFO_DEPTH)+1 bits. Current FIFO occupancy.
- `rf_write`: output, 1 bit. Register file write enable.
- `rf_wrAddr`: output, 5 bits. Register file write address.
- `rf_wrData`: output, 32 bits. Register file write data.

## Operation
- **Late accept:** a late result is accepted when `late_valid & late_ready`. `late_ready = !full & rst_n`. Accepted entries are pushed to the FIFO tail.
- **Writes to x0:** a late result with `late_rd==0` is accepted, pushed and drained normally but never produces `rf_write`. A pipeline write with `pipe_rd==0` is treated as no write, so the port counts as free that cycle.
- **Port arbitration, evaluated each cycle:**
  - If `pipe_we && pipe_rd!=0`: register `{1, pipe_rd, pipe_data}`.
  - Else if the FIFO is non-empty: pop the head and register `{head_rd!=0, head_rd, head_data}`.
  - Otherwise register `rf_write=0`. `rf_wrAddr` and `rf_wrData` hold their previous values.
- **Simultaneous push and pop:** count is unchanged and data order is preserved. A push is never popped in the same cycle it arrives (no bypass).
- **Starvation counter:**
  - Increments on each cycle the FIFO is non-empty and the pipeline occupies the port.
  - Resets to 0 on any pop or when the FIFO is empty.
  - Saturates at `STARVE_LIMIT`.
  - `stall_req = (counter == STARVE_LIMIT)`, registered.
  - Correctness never depends on upstream honouring `stall_req`.
- **Scoreboard** (see Configuration):
  - `claim_valid && claim_rd!=0` sets `busy[claim_rd]`.
  - Popping an entry with rd≠0 clears `busy[rd]` on the same edge that asserts `rf_write` for it. The register file forwards same-cycle writes, so decode may read the register once `busy` drops.
  - Set and clear of the same bit in one cycle: set wins.
  - Claims on x0 are ignored.

## Timing
- **Reset values:**
  - `rf_write=0`, `rf_wrAddr=0`, `rf_wrData=0`.
  - `busy=0`, `stall_req=0`, `fifo_count=0`.
  - `late_ready=0` while `rst_n` is low.
  - FIFO pointers and the starvation counter are 0.
  - Reset mid-operation discards all queued entries and claims immediately (asynchronous).
- **Pipeline path:** `pipe_we` sampled at edge N gives `rf_write` high after edge N, i.e. 1-cycle latency.
- **Late path:** accept at edge N → entry in FIFO after N → earliest `rf_write` after N+1 (2-cycle latency with the port free).
- **Full FIFO:** `late_ready` falls the cycle after the count reaches `FIFO_DEPTH`. It rises the cycle after a pop with no simultaneous push.
- **Busy timing:** `busy` is visible the cycle after the claim edge. The bit clears in the same cycle as the matching `rf_write`.
- **Pointer arithmetic:** `log2(FIFO_DEPTH)` bits, wrapping modulo `FIFO_DEPTH`. Full and empty are distinguished by `fifo_count`.

## Configuration
- `WB_MERGE_SCOREBOARD_EN` defined: the `busy` register and claim logic are built as described above.
- Not defined: `busy` is tied to 0, `claim_valid` and `claim_rd` are ignored, and no scoreboard flops are synthesised. All other behaviour is identical.

## Test plan
- **Reset mid-traffic:** 2 entries queued, `busy[5]=1`, `rst_n` pulsed low mid-cycle → all outputs read 0 immediately. After release `late_ready=1` and nothing drains.
- **Pipeline priority:** `pipe_we=1`, rd=3, data=0xA5A5A5A5 in the same cycle as a late accept for rd=7, data=0x11 → rf write (3, 0xA5A5A5A5) next cycle, then (7, 0x11) one cycle later with `pipe_we=0`.
- **FIFO full:** `pipe_we` held 1 to rd=1 while 3 late results are offered (DEPTH=2) → 2 accepted, `late_ready=0`, `fifo_count=2`. After `STARVE_LIMIT`=8 blocked cycles `stall_req=1`. One bubble pops the head in order and `stall_req` drops.
- **x0 handling:** late result to rd=0 with data 0xFFFFFFFF → accepted and popped, `rf_write` stays 0. `pipe_we` to rd=0 leaves the port free for a queued entry.
- **Scoreboard:** claim rd=9 → `busy[9]=1` next cycle. A late write to 9 drains → `busy[9]=0` in the same cycle `rf_write=1`, `rf_wrAddr=9`. A same-cycle re-claim of 9 keeps `busy[9]=1`.
- **Macro off:** build without `WB_MERGE_SCOREBOARD_EN`, repeat the scoreboard test → `busy` stays 0 throughout and write ordering is unchanged.
